// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle ALU request sequencer with valid/ready handshakes
module alu_sequencer #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic [13:0]      ctrl_onehot,
    output logic             busy
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [WIDTH-1:0] W_MOD = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_XNOR = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;
    localparam logic [3:0] OP_SHR  = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             err_q;
    logic [13:0]      onehot_q;

    logic             multi;
    logic [CW-1:0]    load_cnt;
    logic [13:0]      dec_onehot;

    logic [3:0]       ev_op;
    logic [WIDTH-1:0] ev_a;
    logic [WIDTH-1:0] ev_b;
    logic [WIDTH-1:0] ev_res;
    logic             ev_err;
    logic [WIDTH-1:0] sh;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign out_result  = res_q;
    assign out_err     = err_q;
    assign ctrl_onehot = onehot_q;

    // Latency class of the incoming opcode: multi-cycle ops park in EXEC with a preloaded down-counter
    always_comb begin
        multi    = 1'b0;
        load_cnt = '0;
        if (in_opcode == OP_MUL && MUL_CYCLES > 1) begin
            multi    = 1'b1;
            load_cnt = CW'(MUL_CYCLES - 1);
        end else if (in_opcode == OP_DIV && DIV_CYCLES > 1) begin
            multi    = 1'b1;
            load_cnt = CW'(DIV_CYCLES - 1);
        end
        dec_onehot = (in_opcode <= OP_SHR) ? (14'd1 << in_opcode) : 14'd0;
    end

    // Single shared datapath: fed from the ports when finishing at acceptance, else from captured operands
    always_comb begin
        ev_op  = (state == IDLE) ? in_opcode : op_q;
        ev_a   = (state == IDLE) ? in_a : a_q;
        ev_b   = (state == IDLE) ? in_b : b_q;
        ev_res = '0;
        ev_err = 1'b0;
        sh     = ev_b % W_MOD;
        case (ev_op)
            OP_ADD:  ev_res = ev_a + ev_b;
            OP_SUB:  ev_res = ev_a - ev_b;
            OP_MUL:  ev_res = ev_a * ev_b;
            OP_DIV: begin
                if (ev_b == '0) begin
                    ev_res = '1;
                    ev_err = 1'b1;
                end else begin
                    ev_res = ev_a / ev_b;
                end
            end
            OP_AND:  ev_res = ev_a & ev_b;
            OP_OR:   ev_res = ev_a | ev_b;
            OP_NOT:  ev_res = ~ev_a;
            OP_XOR:  ev_res = ev_a ^ ev_b;
            OP_NAND: ev_res = ~(ev_a & ev_b);
            OP_NOR:  ev_res = ~(ev_a | ev_b);
            OP_XNOR: ev_res = ~(ev_a ^ ev_b);
            OP_SHL:  ev_res = ev_a << sh;
            OP_SHR:  ev_res = ev_a >> sh;
            default: ev_err = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, count down in EXEC, wait for consumer in DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = multi ? EXEC : DONE;
            EXEC: if (cnt == CW'(1)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, latency counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            onehot_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_opcode;
                        a_q      <= in_a;
                        b_q      <= in_b;
                        onehot_q <= dec_onehot;
                        if (multi) begin
                            cnt <= load_cnt;
                        end else begin
                            res_q <= ev_res;
                            err_q <= ev_err;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == CW'(1)) begin
                        res_q <= ev_res;
                        err_q <= ev_err;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) onehot_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL provide parameter MUL_CYCLES, default 4, multiply latency in cycles; legal range >= 1.
REQ-003 SHALL provide parameter DIV_CYCLES, default 16, divide latency in cycles; legal range >= 1.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  sequencer can accept a request.
REQ-008 SHALL have port in_opcode  input  4  operation select.
REQ-009 SHALL have ports in_a, in_b  input  WIDTH  unsigned operands.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_result  output  WIDTH  operation result.
REQ-013 SHALL have port out_err  output  1  illegal opcode or divide-by-zero.
REQ-014 SHALL have port ctrl_onehot  output  14  one-hot op select of the operation in flight.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, EXEC, DONE; in_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with in_valid && in_ready, capturing opcode, in_a, in_b into internal registers.
REQ-018 SHALL decode opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 NOT a, 7 XOR, 8 NAND, 9 NOR, 10 XNOR, 11 a << b, 12 a >> b (logical); 13-15 illegal.
REQ-019 SHALL set ctrl_onehot bit n for opcode n (0..12) from acceptance until output handshake; bit 13 never set; all zero in IDLE and for illegal opcodes.
REQ-020 SHALL truncate ADD/SUB/MUL results to low WIDTH bits (SUB wraps modulo 2^WIDTH); DIV yields unsigned quotient.
REQ-021 SHALL use shift amount = in_b modulo WIDTH for opcodes 11/12.
REQ-022 SHALL assign latency N = MUL_CYCLES for MUL, DIV_CYCLES for DIV, 1 for all other opcodes including illegal.
REQ-023 SHALL transition IDLE->DONE on acceptance if N == 1, else IDLE->EXEC with down-counter loaded to N-1; EXEC->DONE when counter reaches 1 (decrementing each cycle), so out_valid rises exactly N edges after the accepting edge.
REQ-024 SHALL assert out_valid only in DONE, with out_result and out_err stable while out_valid && !out_ready.
REQ-025 SHALL transition DONE->IDLE on the edge where out_ready is high; no same-cycle acceptance of a new request (in_ready rises the following cycle).
REQ-026 SHALL on DIV with in_b == 0 produce out_result all ones and out_err = 1 after DIV_CYCLES.
REQ-027 SHALL on illegal opcode produce out_result 0 and out_err = 1 after 1 cycle; out_err = 0 for all other cases.
REQ-028 SHALL ignore in_opcode/in_a/in_b changes after acceptance; in_valid outside IDLE has no effect.

Reset
REQ-029 SHALL on rst_n low, immediately and regardless of clk: state IDLE, counter 0, in_ready 1, out_valid 0, out_result 0, out_err 0, ctrl_onehot 0, busy 0.
REQ-030 SHALL abandon any in-flight operation on reset without producing a result; first acceptance possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 ADD a=3 b=5, out_ready=1 -> out_valid 1 edge later, out_result 8, ctrl_onehot 14'h0001, out_err 0.
REQ-032 DIV a=100 b=7 -> in_ready and out_valid low for 15 cycles, out_valid at edge 16, result 14, ctrl_onehot 14'h0008 throughout.
REQ-033 DIV a=9 b=0 -> after 16 cycles out_result 16'hFFFF, out_err 1.
REQ-034 MUL a=16'h0100 b=16'h0100 with out_ready low 3 cycles -> result 16'h0000 at edge 4, held stable 3 cycles, IDLE one edge after out_ready rises.
REQ-035 opcode 14 -> out_valid after 1 cycle, out_result 0, out_err 1, ctrl_onehot 0.
REQ-036 rst_n pulsed low mid-DIV (cycle 8) -> outputs at reset values asynchronously, no out_valid; new ADD 1+1 afterwards returns 2.
